ibex_mac_conv3x3_seq: RTL and testbench
=======================================

Name: ibex_mac_conv3x3_seq

Overview:
Sequencer that drives the ibex_mac operand interface to compute one 3x3 filter output per accepted window. It holds nine signed 8-bit coefficients and accepts a packed 9-pixel window over a valid/ready handshake. It issues nine multiply operations to the MAC, one per cycle, and accumulates the 16-bit products internally. It returns the raw accumulator plus a shifted, clamped 8-bit pixel over a second valid/ready handshake. It sits between the vector/filter datapath and ibex_mac, which is purely combinational.

Parameters:
ACC_W, 20, accumulator width; must be >= 20 (9 x 255 x -128 = -293760 fits in signed 20 bits).
SHIFT, 4, arithmetic right shift applied to the accumulator before clamping to 0..255.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
coef_we_i  input  1  coefficient write strobe
coef_idx_i  input  4  coefficient index 0..8
coef_i  input  8  signed coefficient
pix_valid_i  input  1  window valid
pix_ready_o  output  1  window accept
pix_i  input  72  nine unsigned pixels; pixel k at [8k+7:8k]
mac_operand_a_o  output  8  pixel to MAC operand_a
mac_operand_b_o  output  8  coefficient to MAC operand_b
mac_carry_in_o  output  8  tied 0
mac_operator_o  output  4  MAC operator select
mac_result_i  input  16  signed MAC product, same cycle
res_valid_o  output  1  result valid
res_ready_i  input  1  result accept
res_acc_o  output  ACC_W  signed accumulated sum
res_pix_o  output  8  clamped pixel

Behaviour:
- Interface decision: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset effects: state=IDLE; all coefficients, the window register, the accumulator and the index are cleared to 0. res_valid_o=0, res_acc_o=0, res_pix_o=0, mac_operand_a_o=0, mac_operand_b_o=0, mac_operator_o=4'b0000. pix_ready_o=1 from the first cycle after reset is released.
- Reset mid-operation: reset asserted in any state wins. The next cycle is IDLE with the reset values above. No result is emitted for the aborted window.
- IDLE state:
  - pix_ready_o=1.
  - On pix_valid_i && pix_ready_o, latch pix_i, clear the accumulator, set idx=0 and go to RUN.
- RUN state (exactly 9 cycles, idx = 0..8):
  - pix_ready_o=0.
  - mac_operand_a_o = pixel[idx]; mac_operand_b_o = coef[idx]; mac_operator_o = 4'b0010 (multiply); mac_carry_in_o = 0.
  - Each cycle: acc <= acc + sign_extend(mac_result_i).
  - When idx==8, go to DONE.
  - Outside RUN, mac_operator_o=0 and both operands are 0.
- DONE state:
  - res_valid_o=1; res_acc_o = acc.
  - res_pix_o = 0 if (acc >>> SHIFT) < 0; 255 if it is > 255; otherwise the low 8 bits.
  - Outputs stay stable while res_ready_i=0.
  - On res_ready_i, go to IDLE.
- Latency and throughput:
  - res_valid_o rises exactly 10 cycles after the accept edge (9 RUN cycles plus 1).
  - With res_ready_i held high, a new window is accepted at most once every 11 cycles.
- Coefficient writes:
  - Applied only in IDLE. Writes in RUN or DONE are dropped.
  - coef_idx_i > 8 is ignored.
  - A write in the same IDLE cycle as a window accept applies to that window.
- pix_valid_i asserted outside IDLE has no effect; the source must hold the window until it sees pix_ready_o.
- All arithmetic is signed. Products are formed by the MAC as an unsigned pixel times a signed coefficient. The accumulator never wraps within its ACC_W range.

Test Plan:
- Reset: pulse rst_i, then idle -> all outputs 0, pix_ready_o=1, mac_operator_o=0.
- Identity kernel: coef[4]=16, others 0; window with pixel4=200, others 7 -> res_acc_o=3200, res_pix_o=200, res_valid_o exactly 10 cycles after accept. Check that mac_operator_o=4'b0010 for 9 consecutive cycles.
- Clamp both ends:
  - All coef=1, all pixels 255 -> acc=2295, res_pix_o=143.
  - All coef=127 -> acc=291465, res_pix_o=255.
  - All coef=-128 (8'h80) -> acc=-293760, res_pix_o=0.
- Backpressure: hold res_ready_i=0 for 5 cycles while pix_valid_i=1 with a new window -> res_valid_o, res_acc_o and res_pix_o stay stable, pix_ready_o=0. After res_ready_i=1, IDLE follows next cycle and the new window is accepted.
- Coefficient write while busy:
  - Write coef[4]=1 during RUN -> the current result is unchanged and the next window still uses 16.
  - Write with coef_idx_i=9 -> no change.
- Reset mid-RUN at idx=4 -> next cycle IDLE, res_valid_o=0, coefficients 0. A following window with no coefficient writes gives res_acc_o=0.

Source files
------------

// File: rtl/ibex_mac_conv3x3_seq.sv
// ibex_mac_conv3x3_seq
// Walks one 3x3 window through the combinational ibex_mac, one tap per cycle,
// and accumulates the nine signed products into a single filter output. The
// raw sum and a shifted, clamped 8-bit pixel are then held until the consumer
// takes them.
module ibex_mac_conv3x3_seq #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    coef_we_i,
  input  logic [3:0]              coef_idx_i,
  input  logic [7:0]              coef_i,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  input  logic [71:0]             pix_i,
  output logic [7:0]              mac_operand_a_o,
  output logic [7:0]              mac_operand_b_o,
  output logic [7:0]              mac_carry_in_o,
  output logic [3:0]              mac_operator_o,
  input  logic [15:0]             mac_result_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic signed [ACC_W-1:0] res_acc_o,
  output logic [7:0]              res_pix_o
);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] LAST_TAP = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [7:0]              coef_q [9];
  logic [7:0]              win_q  [9];
  logic signed [ACC_W-1:0] acc_q;
  logic [3:0]              idx_q;
  logic signed [ACC_W-1:0] acc_shift;
  logic [7:0]              acc_clamped;
  logic                    accept;

  // A window is only taken while idle; the source holds it until then.
  assign accept = (state_q == IDLE) && pix_valid_i;

  // Carry-in is never needed for a plain product.
  assign mac_carry_in_o = 8'd0;

  // Arithmetic shift keeps the sign so negative sums clamp to zero.
  assign acc_shift = acc_q >>> SHIFT;

  // State register; reset aborts any window in flight without a result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept a window, run nine taps, hold the result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (idx_q == LAST_TAP) state_d = DONE;
      DONE:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coefficient bank; writes only land while idle so a running window sees a stable kernel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 9; k++) coef_q[k] <= '0;
    end else if ((state_q == IDLE) && coef_we_i && (coef_idx_i <= LAST_TAP)) begin
      coef_q[coef_idx_i] <= coef_i;
    end
  end

  // Window capture, tap index and accumulation of the MAC product each RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < 9; k++) win_q[k] <= pix_i[8*k +: 8];
      acc_q <= '0;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_q + ACC_W'($signed(mac_result_i));
      idx_q <= (idx_q == LAST_TAP) ? 4'd0 : idx_q + 4'd1;
    end
  end

  // Clamp the shifted sum into the 0..255 pixel range.
  always_comb begin
    acc_clamped = acc_shift[7:0];
    if (acc_shift[ACC_W-1]) begin
      acc_clamped = 8'd0;
    end else if (|acc_shift[ACC_W-2:8]) begin
      acc_clamped = 8'hFF;
    end
  end

  // Outputs per state; MAC operands are driven only while a tap is being processed.
  always_comb begin
    pix_ready_o     = 1'b0;
    mac_operand_a_o = 8'd0;
    mac_operand_b_o = 8'd0;
    mac_operator_o  = OP_NONE;
    res_valid_o     = 1'b0;
    res_acc_o       = '0;
    res_pix_o       = 8'd0;
    case (state_q)
      IDLE: begin
        pix_ready_o = 1'b1;
      end
      RUN: begin
        mac_operand_a_o = win_q[idx_q];
        mac_operand_b_o = coef_q[idx_q];
        mac_operator_o  = OP_MUL;
      end
      DONE: begin
        res_valid_o = 1'b1;
        res_acc_o   = acc_q;
        res_pix_o   = acc_clamped;
      end
      default: begin
        pix_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ibex_mac_conv3x3_seq.sv
// Bench for ibex_mac_conv3x3_seq: a behavioural MAC feeds the sequencer, a
// cycle-level model of the handshakes and the convolution sum is compared
// against the outputs every cycle, and directed windows pin hand-computed sums.
module tb_ibex_mac_conv3x3_seq;

  localparam int ACC_W = 20;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    coef_we_i;
  logic [3:0]              coef_idx_i;
  logic [7:0]              coef_i;
  logic                    pix_valid_i;
  logic                    pix_ready_o;
  logic [71:0]             pix_i;
  logic [7:0]              mac_operand_a_o;
  logic [7:0]              mac_operand_b_o;
  logic [7:0]              mac_carry_in_o;
  logic [3:0]              mac_operator_o;
  logic [15:0]             mac_result_i;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic signed [ACC_W-1:0] res_acc_o;
  logic [7:0]              res_pix_o;

  int n_vectors     = 0;
  int n_miscompares = 0;
  int cyc           = 0;

  ibex_mac_conv3x3_seq #(.ACC_W(ACC_W), .SHIFT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .coef_we_i      (coef_we_i),
    .coef_idx_i     (coef_idx_i),
    .coef_i         (coef_i),
    .pix_valid_i    (pix_valid_i),
    .pix_ready_o    (pix_ready_o),
    .pix_i          (pix_i),
    .mac_operand_a_o(mac_operand_a_o),
    .mac_operand_b_o(mac_operand_b_o),
    .mac_carry_in_o (mac_carry_in_o),
    .mac_operator_o (mac_operator_o),
    .mac_result_i   (mac_result_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_acc_o      (res_acc_o),
    .res_pix_o      (res_pix_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Stand-in for the combinational ibex_mac: unsigned pixel times signed coefficient.
  function automatic logic [15:0] mac_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    int p;
    p = int'(a) * int'($signed(b));
    return (op == 4'b0010) ? p[15:0] : 16'd0;
  endfunction

  assign mac_result_i = mac_model(mac_operand_a_o, mac_operand_b_o, mac_operator_o);

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_vectors++;
    if (act != exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int m_coef [9];
  int m_win  [9];
  bit m_busy      = 1'b0;
  bit model_valid = 1'b0;
  int m_count;
  int m_acc;
  int m_pix;

  // Every negedge: compare against the model, then advance it with the inputs
  // that the next rising edge will sample.
  always @(negedge clk_i) begin : compare
    bit e_valid;
    bit e_run;
    int sh;
    if (model_valid && !rst_i) begin
      e_valid = m_busy && (m_count == 10);
      e_run   = m_busy && (m_count >= 1) && (m_count <= 9);
      checkOutput("m_ready", pix_ready_o, !m_busy);
      checkOutput("m_valid", res_valid_o, e_valid);
      checkOutput("m_carry", mac_carry_in_o, 0);
      checkOutput("m_op", mac_operator_o, e_run ? 2 : 0);
      checkOutput("m_opa", mac_operand_a_o, e_run ? m_win[m_count-1] : 0);
      checkOutput("m_opb", int'($signed(mac_operand_b_o)), e_run ? m_coef[m_count-1] : 0);
      if (e_valid) begin
        checkOutput("m_acc", int'(res_acc_o), m_acc);
        checkOutput("m_pix", res_pix_o, m_pix);
      end
    end
    if (rst_i) begin
      m_busy      = 1'b0;
      model_valid = 1'b1;
      for (int k = 0; k < 9; k++) m_coef[k] = 0;
    end else if (!m_busy) begin
      if (coef_we_i && coef_idx_i <= 4'd8) m_coef[coef_idx_i] = int'($signed(coef_i));
      if (pix_valid_i) begin
        m_acc = 0;
        for (int k = 0; k < 9; k++) begin
          m_win[k] = int'(pix_i[8*k +: 8]);
          m_acc += m_win[k] * m_coef[k];
        end
        sh    = m_acc >>> 4;
        m_pix = (sh < 0) ? 0 : (sh > 255) ? 255 : sh;
        m_busy  = 1'b1;
        m_count = 1;
      end
    end else if (m_count < 10) begin
      m_count++;
    end else if (res_ready_i) begin
      m_busy = 1'b0;
    end
  end

  // Length of the most recent run of consecutive multiply cycles.
  int op_run   = 0;
  int last_run = 0;
  always @(negedge clk_i) begin
    if (mac_operator_o == 4'b0010) begin
      op_run++;
    end else begin
      if (op_run != 0) last_run = op_run;
      op_run = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic writeCoef(input int idx, input int val);
    coef_we_i  = 1'b1;
    coef_idx_i = idx[3:0];
    coef_i     = val[7:0];
    step();
    coef_we_i  = 1'b0;
  endtask

  task automatic writeAllCoef(input int val);
    for (int k = 0; k < 9; k++) writeCoef(k, val);
  endtask

  // Present a window and hold it until accepted; returns the accept cycle.
  task automatic applyStimulus(input logic [71:0] w, output int acc_cyc);
    bit ok;
    ok          = 1'b0;
    acc_cyc     = 0;
    pix_valid_i = 1'b1;
    pix_i       = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      if (pix_ready_o) begin
        acc_cyc = cyc;
        ok      = 1'b1;
      end
      step();
    end
    pix_valid_i = 1'b0;
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  // Wait for the result and check latency and hand-computed values.
  task automatic awaitResult(input int acc_cyc, input int exp_acc, input int exp_pix,
                             input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      if (res_valid_o) begin
        ok = 1'b1;
        checkOutput({name, "_latency"}, cyc - acc_cyc, 10);
        checkOutput({name, "_acc"}, int'(res_acc_o), exp_acc);
        checkOutput({name, "_pix"}, res_pix_o, exp_pix);
      end
      step();
    end
    if (!ok) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a;
    int hs_cyc;
    logic [71:0] w;

    rst_i       = 1'b1;
    coef_we_i   = 1'b0;
    coef_idx_i  = 4'd0;
    coef_i      = 8'd0;
    pix_valid_i = 1'b0;
    pix_i       = '0;
    res_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state.
    @(negedge clk_i);
    checkOutput("rst_valid", res_valid_o, 0);
    checkOutput("rst_acc", int'(res_acc_o), 0);
    checkOutput("rst_pix", res_pix_o, 0);
    checkOutput("rst_opa", mac_operand_a_o, 0);
    checkOutput("rst_opb", mac_operand_b_o, 0);
    checkOutput("rst_op", mac_operator_o, 0);
    checkOutput("rst_ready", pix_ready_o, 1);
    step();

    // Identity kernel; out-of-range index must not alias onto a real tap.
    $display("[TB] identity kernel");
    writeCoef(4, 16);
    writeCoef(9, 55);
    w = {9{8'd7}};
    w[39:32] = 8'd200;
    applyStimulus(w, a);
    writeCoef(4, 1);
    awaitResult(a, 3200, 200, "ident");
    checkOutput("ident_mul_cycles", last_run, 9);

    // Busy write was dropped: coefficient 4 is still 16.
    w[39:32] = 8'd100;
    applyStimulus(w, a);
    awaitResult(a, 1600, 100, "ident2");

    // Clamp behaviour.
    $display("[TB] clamp tests");
    writeAllCoef(1);
    applyStimulus({9{8'hFF}}, a);
    awaitResult(a, 2295, 143, "ones");
    writeAllCoef(127);
    applyStimulus({9{8'hFF}}, a);
    awaitResult(a, 291465, 255, "maxpos");
    writeAllCoef(-128);
    applyStimulus({9{8'hFF}}, a);
    awaitResult(a, -293760, 0, "maxneg");

    // Backpressure with a new window waiting.
    $display("[TB] backpressure");
    res_ready_i = 1'b0;
    applyStimulus({9{8'hFF}}, a);
    awaitResult(a, -293760, 0, "bp_first");
    w = '0;
    w[7:0] = 8'd2;
    pix_valid_i = 1'b1;
    pix_i       = w;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("bp_hold_valid", res_valid_o, 1);
      checkOutput("bp_hold_acc", int'(res_acc_o), -293760);
      checkOutput("bp_hold_pix", res_pix_o, 0);
      checkOutput("bp_hold_ready", pix_ready_o, 0);
      step();
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    hs_cyc = cyc;
    step();
    applyStimulus(w, a);
    checkOutput("bp_accept_cycle", a, hs_cyc + 1);
    awaitResult(a, -256, 0, "bp_second");

    // Reset in the middle of RUN at tap 4.
    $display("[TB] reset mid-run");
    applyStimulus({9{8'hFF}}, a);
    repeat (4) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("mid_rst_valid", res_valid_o, 0);
    checkOutput("mid_rst_ready", pix_ready_o, 1);
    checkOutput("mid_rst_op", mac_operator_o, 0);
    step();
    applyStimulus({9{8'hFF}}, a);
    awaitResult(a, 0, 0, "post_rst");

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
